// File: rtl/fir_decimator_fifo.sv
// Decimates the FIR output stream, rescales each kept sample with an arithmetic shift
// and saturation, and buffers the results in a show-ahead FIFO behind a valid/ready port.
module fir_decimator_fifo #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        fir_y,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Down-counter of samples still to skip; a sample is kept when it reads zero.
  logic [PH_W-1:0] skip_cnt;
  logic            keep;

  logic signed [DATA_W-1:0] shifted;
  logic [OUT_W-1:0]         sat_val;

  logic             st_valid;
  logic [OUT_W-1:0] st_data;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;

  logic             pop;
  logic             wr_ok;
  logic             drop;
  logic [OUT_W-1:0] head_n;
  logic [CW-1:0]    count_n;

  assign keep    = in_valid && (skip_cnt == '0);
  assign shifted = $signed(fir_y) >>> SHIFT;

  always_comb begin
    sat_val = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX)
      sat_val = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN)
      sat_val = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt <= '0;
      st_valid <= 1'b0;
      st_data  <= '0;
    end else begin
      if (in_valid)
        skip_cnt <= (skip_cnt == '0) ? PH_W'(DECIM - 1) : skip_cnt - 1'b1;
      st_valid <= keep;
      if (keep)
        st_data <= sat_val;
    end
  end

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign drop      = st_valid && (fifo_count == CW'(DEPTH)) && !pop;
  assign wr_ok     = st_valid && !drop;
  assign rd_next   = rd_ptr + AW'(1);

  always_comb begin
    count_n = fifo_count;
    if (wr_ok && !pop)
      count_n = fifo_count + CW'(1);
    else if (pop && !wr_ok)
      count_n = fifo_count - CW'(1);
  end

  // out_data is a register so it can hold the last head once the FIFO drains.
  always_comb begin
    head_n = out_data;
    if (pop) begin
      if (fifo_count > CW'(1))
        head_n = mem[rd_next];
      else if (wr_ok)
        head_n = st_data;
    end else if (fifo_count == '0 && wr_ok) begin
      head_n = st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok)
      mem[wr_ptr] <= st_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_next;
      fifo_count <= count_n;
      out_data   <= head_n;
      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decimator_fifo.sv
// Directed bench for fir_decimator_fifo: several parameterisations share one stimulus
// bus; a reference model queue supplies the expected head, count and overflow.
module tb_fir_decimator_fifo;

  localparam int SEL_A = 0;  // DECIM=4 SHIFT=0  OUT_W=32 DEPTH=16
  localparam int SEL_B = 1;  // DECIM=1 SHIFT=16 OUT_W=16 DEPTH=8
  localparam int SEL_C = 2;  // DECIM=1 SHIFT=4  OUT_W=16 DEPTH=8
  localparam int SEL_D = 3;  // DECIM=3 SHIFT=0  OUT_W=16 DEPTH=8

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fir_y = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;

  logic [31:0] a_data;  logic a_valid; logic [4:0] a_count; logic a_ovf;
  logic [15:0] b_data;  logic b_valid; logic [3:0] b_count; logic b_ovf;
  logic [15:0] c_data;  logic c_valid; logic [3:0] c_count; logic c_ovf;
  logic [15:0] d_data;  logic d_valid; logic [3:0] d_count; logic d_ovf;

  always #5 clk = ~clk;

  fir_decimator_fifo #(.DATA_W(32), .OUT_W(32), .SHIFT(0), .DECIM(4), .DEPTH(16)) u_a (
    .clk(clk), .reset(reset), .fir_y(fir_y), .in_valid(in_valid), .out_data(a_data),
    .out_valid(a_valid), .out_ready(out_ready), .fifo_count(a_count), .overflow(a_ovf),
    .clear_overflow(clear_overflow));
  fir_decimator_fifo #(.DATA_W(32), .OUT_W(16), .SHIFT(16), .DECIM(1), .DEPTH(8)) u_b (
    .clk(clk), .reset(reset), .fir_y(fir_y), .in_valid(in_valid), .out_data(b_data),
    .out_valid(b_valid), .out_ready(out_ready), .fifo_count(b_count), .overflow(b_ovf),
    .clear_overflow(clear_overflow));
  fir_decimator_fifo #(.DATA_W(32), .OUT_W(16), .SHIFT(4), .DECIM(1), .DEPTH(8)) u_c (
    .clk(clk), .reset(reset), .fir_y(fir_y), .in_valid(in_valid), .out_data(c_data),
    .out_valid(c_valid), .out_ready(out_ready), .fifo_count(c_count), .overflow(c_ovf),
    .clear_overflow(clear_overflow));
  fir_decimator_fifo #(.DATA_W(32), .OUT_W(16), .SHIFT(0), .DECIM(3), .DEPTH(8)) u_d (
    .clk(clk), .reset(reset), .fir_y(fir_y), .in_valid(in_valid), .out_data(d_data),
    .out_valid(d_valid), .out_ready(out_ready), .fifo_count(d_count), .overflow(d_ovf),
    .clear_overflow(clear_overflow));

  int sel = SEL_A;
  logic signed [63:0] obs_data;
  logic               obs_valid;
  logic [63:0]        obs_count;
  logic               obs_ovf;

  always_comb begin
    obs_data  = '0;
    obs_valid = 1'b0;
    obs_count = '0;
    obs_ovf   = 1'b0;
    case (sel)
      SEL_A: begin obs_data = 64'($signed(a_data)); obs_valid = a_valid; obs_count = 64'(a_count); obs_ovf = a_ovf; end
      SEL_B: begin obs_data = 64'($signed(b_data)); obs_valid = b_valid; obs_count = 64'(b_count); obs_ovf = b_ovf; end
      SEL_C: begin obs_data = 64'($signed(c_data)); obs_valid = c_valid; obs_count = 64'(c_count); obs_ovf = c_ovf; end
      default: begin obs_data = 64'($signed(d_data)); obs_valid = d_valid; obs_count = 64'(d_count); obs_ovf = d_ovf; end
    endcase
  end

  int n_assert = 0;
  int n_fail = 0;

  int p_decim = 4, p_shift = 0, p_outw = 32, p_depth = 16;

  // Reference model state
  longint mq[$];
  bit     st_v = 1'b0;
  longint st_val = 0;
  int     phase = 0;
  bit     m_ovf = 1'b0;
  longint m_head = 0;
  longint got[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input logic [31:0] y);
    longint s, mx, mn;
    s  = longint'($signed(y)) >>> p_shift;
    mx = (longint'(1) << (p_outw - 1)) - 1;
    mn = -(longint'(1) << (p_outw - 1));
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
  endfunction

  task automatic select(input int s);
    sel = s;
    case (s)
      SEL_A: begin p_decim = 4; p_shift = 0;  p_outw = 32; p_depth = 16; end
      SEL_B: begin p_decim = 1; p_shift = 16; p_outw = 16; p_depth = 8;  end
      SEL_C: begin p_decim = 1; p_shift = 4;  p_outw = 16; p_depth = 8;  end
      default: begin p_decim = 3; p_shift = 0; p_outw = 16; p_depth = 8; end
    endcase
  endtask

  task automatic step(input bit rst, input bit v, input logic [31:0] y, input bit rdy, input bit clr);
    bit m_pop, m_drop;
    reset = rst; in_valid = v; fir_y = y; out_ready = rdy; clear_overflow = clr;
    #1;
    if (!rst && obs_valid && rdy)
      got.push_back(obs_data);
    @(posedge clk);
    if (rst) begin
      mq.delete(); st_v = 1'b0; phase = 0; m_ovf = 1'b0; m_head = 0;
    end else begin
      m_pop  = (mq.size() != 0) && rdy;
      m_drop = st_v && (mq.size() == p_depth) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (st_v && !m_drop) mq.push_back(st_val);
      if (m_drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      st_v = v && (phase == 0);
      if (st_v) st_val = sat(y);
      if (v) phase = (phase + 1) % p_decim;
      if (mq.size() != 0) m_head = mq[0];
    end
    #1;
    chk("count", obs_count, 64'(mq.size()));
    chk("valid", 64'(obs_valid), 64'(mq.size() != 0));
    chk("data", obs_data, m_head);
    chk("ovf", 64'(obs_ovf), 64'(m_ovf));
  endtask

  task automatic chk_got(input string tag, input longint exp[$]);
    chk({tag, "_n"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < got.size()) chk(tag, got[i], exp[i]);
  endtask

  initial begin
    longint exp[$];

    // 1: decimation by 4 and two-edge latency
    select(SEL_A);
    step(1, 0, 0, 0, 0);
    got.delete();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 32'(i), 1, 0);
      if (i == 0) chk("lat_edge_n", 64'(obs_valid), 64'(0));
      if (i == 1) chk("lat_edge_n1", 64'(obs_valid), 64'(1));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    exp = '{0, 4, 8, 12};
    chk_got("decim", exp);

    // 2: scaling and saturation
    select(SEL_B);
    step(1, 0, 0, 0, 0);
    got.delete();
    step(0, 1, 32'h7FFF_FFFF, 1, 0);
    step(0, 1, 32'h8000_0000, 1, 0);
    step(0, 1, 32'h1234_5678, 1, 0);
    step(0, 1, 32'hFFFF_FFE0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    exp = '{32767, -32768, 4660, -1};
    chk_got("scale", exp);

    select(SEL_C);
    step(1, 0, 0, 0, 0);
    got.delete();
    step(0, 1, 32'h0010_0000, 1, 0);
    step(0, 1, 32'hF000_0000, 1, 0);
    step(0, 1, 32'h0000_1230, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    exp = '{32767, -32768, 291};
    chk_got("sat4", exp);

    // 3: backpressure and overflow
    select(SEL_B);
    step(1, 0, 0, 0, 0);
    got.delete();
    for (int k = 1; k <= 10; k++) step(0, 1, 32'(k) << 16, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("full_count", obs_count, 64'(8));
    chk("full_ovf", 64'(obs_ovf), 64'(1));
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
    exp = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_got("drain", exp);
    chk("drained_valid", 64'(obs_valid), 64'(0));
    step(0, 0, 0, 1, 1);
    chk("ovf_clear", 64'(obs_ovf), 64'(0));

    // 4: full with simultaneous push and pop
    step(1, 0, 0, 0, 0);
    got.delete();
    exp.delete();
    for (int k = 1; k <= 9; k++) step(0, 1, 32'(k) << 16, 0, 0);
    for (int k = 10; k <= 24; k++) begin
      step(0, 1, 32'(k) << 16, 1, 0);
      chk("pp_count", obs_count, 64'(8));
      chk("pp_ovf", 64'(obs_ovf), 64'(0));
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
    for (int k = 1; k <= 24; k++) exp.push_back(longint'(k));
    chk_got("pushpop", exp);

    // 5: gapped input, decimation by 3
    select(SEL_D);
    step(1, 0, 0, 0, 0);
    got.delete();
    begin
      bit pat[10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
      for (int i = 0; i < 10; i++) step(0, pat[i], 32'(i), 1, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    exp = '{0, 6, 9};
    chk_got("gapped", exp);

    // 6: reset with buffered and in-flight samples
    select(SEL_A);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i <= 20; i++) step(0, 1, 32'(100 + i), 0, 0);
    chk("pre_rst_count", obs_count, 64'(5));
    step(1, 1, 32'd555, 1, 0);
    chk("rst_count", obs_count, 64'(0));
    chk("rst_valid", 64'(obs_valid), 64'(0));
    chk("rst_ovf", 64'(obs_ovf), 64'(0));
    chk("rst_data", obs_data, 64'(0));
    step(0, 1, 32'd99, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_count", obs_count, 64'(1));
    chk("post_rst_data", obs_data, 64'(99));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
